// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with immediate range checks and a 2-entry address-tagged output buffer
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        addr_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t        occ_q, occ_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] slot0_instr_q, slot0_instr_d;
    logic [31:0] slot0_addr_q, slot0_addr_d;
    logic [31:0] slot1_instr_q, slot1_instr_d;
    logic [31:0] slot1_addr_q, slot1_addr_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_count_q, err_count_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        imm12_ok;
    logic        imm13_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] push_addr;

    // Signed 12-bit fits when bits [31:11] are a pure sign extension; 13-bit likewise from bit 12.
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm13_ok = (&imm[31:12]) | ~(|imm[31:12]);

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (op_sel)
            4'd0: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
            4'd1: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
            4'd2: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
            4'd3: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
            4'd4: begin
                enc_word  = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
                enc_legal = imm12_ok;
            end
            4'd5: begin
                enc_word  = {imm[11:0], rs1, 3'b110, rd, OPC_IMM};
                enc_legal = imm12_ok;
            end
            4'd6: begin
                enc_word  = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                enc_legal = imm12_ok;
            end
            4'd7: begin
                enc_word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STOR};
                enc_legal = imm12_ok;
            end
            4'd8: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
                enc_legal = imm13_ok & ~imm[0];
            end
            4'd9: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], OPC_BR};
                enc_legal = imm13_ok & ~imm[0];
            end
            4'd10: enc_word = {imm[31:12], rd, OPC_LUI};
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = (occ_q != OCC_TWO);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign accept    = in_valid & in_ready;
    assign push      = accept & enc_legal;
    assign pop       = out_valid & out_ready;
    // A clear in the same cycle as a push tags that word with the base address.
    assign push_addr = addr_clr ? BASE_ADDR : addr_q;

    always_comb begin
        addr_d = addr_q;
        if (push) begin
            addr_d = push_addr + 32'd4;
        end else if (addr_clr) begin
            addr_d = BASE_ADDR;
        end
    end

    always_comb begin
        err_pulse_d = accept & ~enc_legal;
        err_count_d = err_count_q;
        if (accept && !enc_legal && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Slot 0 is always the head; it keeps its last contents while empty so the outputs never go X.
    always_comb begin
        occ_d         = occ_q;
        slot0_instr_d = slot0_instr_q;
        slot0_addr_d  = slot0_addr_q;
        slot1_instr_d = slot1_instr_q;
        slot1_addr_d  = slot1_addr_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    slot0_instr_d = enc_word;
                    slot0_addr_d  = push_addr;
                    occ_d         = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    slot0_instr_d = enc_word;
                    slot0_addr_d  = push_addr;
                end else if (push) begin
                    slot1_instr_d = enc_word;
                    slot1_addr_d  = push_addr;
                    occ_d         = OCC_TWO;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    slot0_instr_d = slot1_instr_q;
                    slot0_addr_d  = slot1_addr_q;
                    occ_d         = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= OCC_EMPTY;
            addr_q        <= BASE_ADDR;
            slot0_instr_q <= 32'h0;
            slot0_addr_q  <= 32'h0;
            slot1_instr_q <= 32'h0;
            slot1_addr_q  <= 32'h0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= 8'h0;
        end else begin
            occ_q         <= occ_d;
            addr_q        <= addr_d;
            slot0_instr_q <= slot0_instr_d;
            slot0_addr_q  <= slot0_addr_d;
            slot1_instr_q <= slot1_instr_d;
            slot1_addr_q  <= slot1_addr_d;
            err_pulse_q   <= err_pulse_d;
            err_count_q   <= err_count_d;
        end
    end

    assign out_instr = slot0_instr_q;
    assign out_addr  = slot0_addr_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_pulse;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr;
    int          exp_err;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[19];

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Scoreboard: every word the consumer takes must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got 0x%08h @0x%08h expected none", out_instr, out_addr);
            end else begin
                chk("sb_instr", out_instr, sb[0][63:32]);
                chk("sb_addr", out_addr, sb[0][31:0]);
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_addr = 32'h0;
        exp_err = 0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic [31:0] a_imm, input logic clr,
                        input logic legal, input logic [31:0] instr);
        logic [31:0] tag;
        int n;
        op_sel = op; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; imm = a_imm;
        addr_clr = clr;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck 0 expected 1");
            in_valid = 1'b0;
            addr_clr = 1'b0;
            return;
        end
        tag = clr ? 32'h0 : exp_addr;
        if (legal) begin
            sb.push_back({instr, tag});
            exp_addr = tag + 32'd4;
        end else begin
            if (clr) exp_addr = 32'h0;
            if (exp_err < 255) exp_err++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
        chk("err_pulse", {31'h0, err_pulse}, {31'h0, ~legal});
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{4'd4,  5'd5,  5'd0,  5'd0, 32'd2048,      1'b0, 32'h0};
        vecs[1]  = '{4'd8,  5'd0,  5'd1,  5'd2, 32'd7,         1'b0, 32'h0};
        vecs[2]  = '{4'd12, 5'd1,  5'd1,  5'd1, 32'd0,         1'b0, 32'h0};
        vecs[3]  = '{4'd0,  5'd3,  5'd1,  5'd2, 32'd0,         1'b1, 32'h002081B3};
        vecs[4]  = '{4'd4,  5'd5,  5'd0,  5'd9, 32'hFFFFFFFF,  1'b1, 32'hFFF00293};
        vecs[5]  = '{4'd7,  5'd0,  5'd1,  5'd2, 32'd8,         1'b1, 32'h0020A423};
        vecs[6]  = '{4'd8,  5'd0,  5'd1,  5'd2, 32'd8,         1'b1, 32'h00208463};
        vecs[7]  = '{4'd10, 5'd7,  5'd3,  5'd4, 32'h12345000,  1'b1, 32'h123453B7};
        vecs[8]  = '{4'd1,  5'd1,  5'd2,  5'd3, 32'd0,         1'b1, 32'h403100B3};
        vecs[9]  = '{4'd2,  5'd4,  5'd5,  5'd6, 32'd0,         1'b1, 32'h0062F233};
        vecs[10] = '{4'd3,  5'd7,  5'd8,  5'd9, 32'd0,         1'b1, 32'h009463B3};
        vecs[11] = '{4'd5,  5'd10, 5'd11, 5'd0, 32'h000007FF,  1'b1, 32'h7FF5E513};
        vecs[12] = '{4'd6,  5'd12, 5'd13, 5'd0, 32'hFFFFF800,  1'b1, 32'h8006A603};
        vecs[13] = '{4'd9,  5'd0,  5'd3,  5'd4, 32'hFFFFFFFC,  1'b1, 32'hFE41CEE3};
        vecs[14] = '{4'd8,  5'd0,  5'd0,  5'd0, 32'd4094,      1'b1, 32'h7E000FE3};
        vecs[15] = '{4'd8,  5'd0,  5'd0,  5'd0, 32'd4096,      1'b0, 32'h0};
        vecs[16] = '{4'd7,  5'd0,  5'd1,  5'd2, 32'hFFFFF7FF,  1'b0, 32'h0};
        vecs[17] = '{4'd10, 5'd0,  5'd5,  5'd6, 32'hFFFFFFFF,  1'b1, 32'hFFFFF037};
        vecs[18] = '{4'd15, 5'd1,  5'd1,  5'd1, 32'd0,         1'b0, 32'h0};

        op_sel = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0;
        out_ready = 1'b1;
        rst = 1'b1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_err_pulse", {31'h0, err_pulse}, 32'd0);
        chk("rst_err_count", {24'h0, err_count}, 32'd0);
        do_reset();

        for (int i = 0; i < 19; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0,
                 vecs[i].legal, vecs[i].instr);
            if (i == 2) begin
                chk("illegal_no_valid", {31'h0, out_valid}, 32'd0);
                chk("illegal_count3", {24'h0, err_count}, 32'd3);
            end
            if (i == 3) chk("add_latency_valid", {31'h0, out_valid}, 32'd1);
        end
        chk("table_err_count", {24'h0, err_count}, exp_err);
        drain();

        // Stalled consumer: two words fill the buffer, the third must wait.
        do_reset();
        out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        chk("stall_ready_after1", {31'h0, in_ready}, 32'd1);
        send(4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h403100B3);
        chk("stall_ready_after2", {31'h0, in_ready}, 32'd0);
        op_sel = 4'd3; rd = 5'd7; rs1 = 5'd8; rs2 = 5'd9; imm = 32'h0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
            chk("stall_hold_instr", out_instr, 32'h002081B3);
            chk("stall_hold_addr", out_addr, 32'h0);
        end
        out_ready = 1'b1;
        send(4'd3, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 1'b1, 32'h009463B3);
        drain();
        chk("stall_next_addr", exp_addr, 32'hC);

        // addr_clr together with a push after five words.
        do_reset();
        for (int k = 0; k < 5; k++)
            send(4'd2, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b1, 32'h0062F233);
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3);
        send(4'd10, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 32'h123453B7);
        drain();

        // Reset while two words are buffered.
        out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(4'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h403100B3);
        chk("full_valid", {31'h0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_addr = 32'h0;
        exp_err = 0;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("midrst_err_pulse", {31'h0, err_pulse}, 32'd0);
        out_ready = 1'b1;
        send(4'd4, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFF00293);
        drain();

        // Error counter saturation.
        for (int k = 0; k < 260; k++) begin
            send(4'd13, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0);
            if (k == 253) chk("err_count_254", {24'h0, err_count}, 32'd254);
        end
        chk("err_count_sat", {24'h0, err_count}, 32'd255);
        chk("err_model_sat", exp_err, 32'd255);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder: the inverse of the control/decode path. It accepts symbolic operation requests and packs them into 32-bit RV32I words. It also range-checks immediates and streams each word, tagged with its byte address, toward instruction-memory load logic through a 2-entry output buffer. The supported set is exactly what the datapath decodes: ADD, SUB, AND, OR, ADDI, ORI, LW, SW, BEQ, BLT, LUI.

## Interface
- BASE_ADDR, 32'h0000_0000, address tagged to the first word after reset or `addr_clr`.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when `in_valid & in_ready`.
- op_sel  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 ORI, 6 LW, 7 SW, 8 BEQ, 9 BLT, 10 LUI; 11–15 illegal.
- rd, rs1, rs2  in  5 each  register indices; unused fields are ignored (encoded per format only).
- imm  in  32  immediate: byte offset for branches; full 32-bit value for LUI (uses imm[31:12]).
- addr_clr  in  1  restart address counter at BASE_ADDR.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer pop when `out_valid & out_ready`.
- out_instr  out  32  encoded word at buffer head.
- out_addr  out  32  byte address of out_instr.
- err_pulse  out  1  one-cycle pulse: the request accepted on the previous edge was illegal.
- err_count  out  8  saturating count of illegal requests.

## Operation
- Formats, opcode/funct3/funct7:
  - R 0110011: ADD 000/0000000, SUB 000/0100000, AND 111/0000000, OR 110/0000000.
  - I: ADDI 0010011/000, ORI 0010011/110, LW 0000011/010; imm[11:0] in [31:20].
  - S: SW 0100011/010; imm[11:5] in [31:25], imm[4:0] in [11:7].
  - B 1100011: BEQ 000, BLT 100; {imm[12], imm[10:5]} in [31:25], {imm[4:1], imm[11]} in [11:7].
  - U: LUI 0110111; imm[31:12] in [31:12], rd in [11:7].
- Legality checks; a failing request is illegal:
  - I/S: imm[31:11] must be all-equal (signed 12-bit).
  - B: imm[31:12] must be all-equal (signed 13-bit) and imm[0] must be 0.
  - LUI: imm[11:0] is ignored, no check.
  - op_sel 11–15 is always illegal.
- Accepted legal request: encoded word and current address pushed into the FIFO; address counter += 4, wrapping modulo 2^32.
- Accepted illegal request: nothing pushed; address unchanged; err_pulse on the next cycle; err_count +1, saturating at 255.
- addr_clr:
  - Counter ← BASE_ADDR.
  - If a legal push occurs in the same cycle, that word is tagged BASE_ADDR and the counter becomes BASE_ADDR+4.
- FIFO: 2 entries, in-order, registered storage; push and pop in the same cycle are allowed when not full.
- in_ready = (occupancy < 2). It depends only on registered state, never on out_ready, so a full buffer refuses input even when a pop happens the same cycle.
- out_instr/out_addr must hold stable while `out_valid & !out_ready`.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=0, err_pulse=0, err_count=0, address counter=BASE_ADDR, occupancy=0.
- Reset mid-stream discards buffered words and does not raise err_pulse.
- Latency: a word accepted at edge N is visible (out_valid=1) after edge N; throughput is 1 word/cycle with out_ready held high.
- Empty: out_valid=0; head outputs are don't-care but must not X-propagate, so they hold their last value.
- Full: in_ready=0 until the edge after a pop.
- State (occupancy): EMPTY→ONE on push; ONE→TWO on push without pop; ONE→EMPTY on pop without push; ONE stays on push+pop; TWO→ONE on pop.

## Test plan
- ADD rd=3 rs1=1 rs2=2 after reset, out_ready=1 → out_instr=0x002081B3, out_addr=0x0 one cycle later.
- ADDI rd=5 rs1=0 imm=-1, then SW rs1=1 rs2=2 imm=8 back-to-back → 0xFFF00293 @0x0, then 0x0020A423 @0x4.
- BEQ rs1=1 rs2=2 imm=8, then LUI rd=7 imm=0x12345000 → 0x00208463 @0x0, then 0x123453B7 @0x4.
- ADDI imm=2048, BEQ imm=7, op_sel=12 → each gives an err_pulse; err_count=3; no out_valid; next legal word tagged 0x0.
- out_ready=0 with 3 consecutive requests → in_ready falls after 2 pushes; third held; release out_ready → words drain in order at addresses 0x0, 0x4, 0x8, data stable while stalled.
- addr_clr asserted together with a legal push after 5 words → that word tagged BASE_ADDR, next tagged BASE_ADDR+4; reset with 2 words buffered → out_valid=0 the following cycle.
